matrix_3x3_gen: RTL and testbench

MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

---
 rtl/matrix_3x3_gen.sv | 188 ++++++++++++++++++
 tb/tb_matrix_3x3_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_3x3_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// matrix_3x3_gen
// Builds a 3x3 pixel neighbourhood from a raster stream and two line-buffer
// taps. Pixels on the frame border are substituted, so every output window is
// well defined. The pipeline is two stages deep: a shift window, then border
// substitution into the output registers.
//
// Build option:
//   MATRIX_BORDER_REPLICATE_EN  defined   -> border entries copy the nearest
//                                            valid row/column (edge replicate)
//                               undefined -> border entries are zero (zero pad)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   in_vsync        frame sync, high between frames
//   in_href         pixel valid, high during the active line
//   in_data         current pixel (row r, column c)
//   taps0x          line-buffer tap, row r-1, column c, aligned with in_data
//   taps1x          line-buffer tap, row r-2, column c, aligned with in_data
//   line_ce         line-buffer shift enable (combinational copy of in_href)
//   m11..m33        window, mRC: R=1 top (r-2) .. R=3 bottom (r),
//                   C=1 oldest (c-2) .. C=3 newest (c)
//   out_vsync       in_vsync delayed by 2 cycles
//   out_href        in_href delayed by 2 cycles (window valid)
//   out_frame_start one-cycle pulse with the first window of a frame
// -----------------------------------------------------------------------------
module matrix_3x3_gen #(
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned IMG_VDISP = 480,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] taps0x,
  input  logic [DATA_W-1:0] taps1x,
  output logic              line_ce,
  output logic [DATA_W-1:0] m11,
  output logic [DATA_W-1:0] m12,
  output logic [DATA_W-1:0] m13,
  output logic [DATA_W-1:0] m21,
  output logic [DATA_W-1:0] m22,
  output logic [DATA_W-1:0] m23,
  output logic [DATA_W-1:0] m31,
  output logic [DATA_W-1:0] m32,
  output logic [DATA_W-1:0] m33,
  output logic              out_vsync,
  output logic              out_href,
  output logic              out_frame_start
);

  localparam int unsigned COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam bit REPLICATE = 1'b1;
`else
  localparam bit REPLICATE = 1'b0;
`endif

  // Window arrays are indexed [row][col]: row 0 = top (r-2), col 2 = newest.
  logic [2:0][2:0][DATA_W-1:0] r_win;
  logic [2:0][2:0][DATA_W-1:0] w_row_sub;
  logic [2:0][2:0][DATA_W-1:0] w_win;
  logic [2:0][2:0][DATA_W-1:0] r_m;

  logic             r_s1_href;
  logic             r_s1_vsync;
  logic [COL_W-1:0] r_col_cnt;
  logic [ROW_W-1:0] r_row_cnt;
  logic [COL_W-1:0] r_s1_col;
  logic [ROW_W-1:0] r_s1_row;
  logic             w_href_fall;
  logic             w_vsync_rise;

  // Line buffer advances with every valid pixel, reset or not.
  assign line_ce = in_href;

  // Stage-1 copies of in_href/in_vsync double as the edge-detect history.
  assign w_href_fall  = r_s1_href & ~in_href;
  assign w_vsync_rise = in_vsync & ~r_s1_vsync;

  // Column position of the pixel currently on in_data; parks at the last column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
    end else if (!in_href) begin
      r_col_cnt <= '0;
    end else if (r_col_cnt != COL_MAX) begin
      r_col_cnt <= r_col_cnt + COL_W'(1);
    end
  end

  // Row position; a frame start clears it even if a line ends in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
    end else if (w_vsync_rise) begin
      r_row_cnt <= '0;
    end else if (w_href_fall && (r_row_cnt != ROW_MAX)) begin
      r_row_cnt <= r_row_cnt + ROW_W'(1);
    end
  end

  // Stage 1: shift the three rows and capture the pixel's position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_href  <= 1'b0;
      r_s1_vsync <= 1'b0;
      r_win      <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
    end else begin
      r_s1_href  <= in_href;
      r_s1_vsync <= in_vsync;
      if (in_href) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= taps1x;
        r_win[1][2] <= taps0x;
        r_win[2][2] <= in_data;
        r_s1_col    <= r_col_cnt;
        r_s1_row    <= r_row_cnt;
      end
    end
  end

  // Rows above the frame top take the nearest real row (or zero).
  always_comb begin
    w_row_sub = r_win;
    if (r_s1_row == '0) begin
      w_row_sub[0] = REPLICATE ? r_win[2] : '0;
      w_row_sub[1] = REPLICATE ? r_win[2] : '0;
    end else if (r_s1_row == ROW_W'(1)) begin
      w_row_sub[0] = REPLICATE ? r_win[1] : '0;
    end
  end

  // Columns left of the line start, applied after the row substitution so
  // corner entries resolve to the single valid pixel.
  always_comb begin
    w_win = w_row_sub;
    for (int r = 0; r < 3; r++) begin
      if (r_s1_col == '0) begin
        w_win[r][0] = REPLICATE ? w_row_sub[r][2] : '0;
        w_win[r][1] = REPLICATE ? w_row_sub[r][2] : '0;
      end else if (r_s1_col == COL_W'(1)) begin
        w_win[r][0] = REPLICATE ? w_row_sub[r][1] : '0;
      end
    end
  end

  // Stage 2: register the substituted window; hold it while no pixel is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m             <= '0;
      out_href        <= 1'b0;
      out_vsync       <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      out_href        <= r_s1_href;
      out_vsync       <= r_s1_vsync;
      out_frame_start <= r_s1_href && (r_s1_row == '0) && (r_s1_col == '0);
      if (r_s1_href) begin
        r_m <= w_win;
      end
    end
  end

  assign m11 = r_m[0][0];
  assign m12 = r_m[0][1];
  assign m13 = r_m[0][2];
  assign m21 = r_m[1][0];
  assign m22 = r_m[1][1];
  assign m23 = r_m[1][2];
  assign m31 = r_m[2][0];
  assign m32 = r_m[2][1];
  assign m33 = r_m[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_matrix_3x3_gen
// Directed bench for matrix_3x3_gen with a 4x3 image, pixel = 16*row+col+1.
// The bench acts as the line buffer, records outputs every cycle and checks
// selected windows against hand-computed values two cycles after the pixel.
// -----------------------------------------------------------------------------
module tb_matrix_3x3_gen;

  localparam int unsigned HD   = 4;
  localparam int unsigned VD   = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREC = 1024;

  // Expected windows {m11,m12,m13,m21,m22,m23,m31,m32,m33} at (row,col).
`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam logic [71:0] E00 = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
  localparam logic [71:0] E10 = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h11, 8'h11, 8'h11};
  localparam logic [71:0] E11 = {8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h02, 8'h11, 8'h11, 8'h12};
  localparam logic [71:0] E03 = {8'h02, 8'h03, 8'h04, 8'h02, 8'h03, 8'h04, 8'h02, 8'h03, 8'h04};
  localparam logic [71:0] E05 = {8'h04, 8'h05, 8'h06, 8'h04, 8'h05, 8'h06, 8'h04, 8'h05, 8'h06};
`else
  localparam logic [71:0] E00 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  localparam logic [71:0] E10 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h11};
  localparam logic [71:0] E11 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h11, 8'h12};
  localparam logic [71:0] E03 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h04};
  localparam logic [71:0] E05 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h05, 8'h06};
`endif
  localparam logic [71:0] E23 = {8'h02, 8'h03, 8'h04, 8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24};
  localparam logic [71:0] E32 = {8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_vsync = 1'b0;
  logic          in_href  = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic [DW-1:0] taps0x   = '0;
  logic [DW-1:0] taps1x   = '0;
  logic          line_ce;
  logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
  logic          out_vsync, out_href, out_frame_start;
  logic [71:0]   w_win;

  assign w_win = {m11, m12, m13, m21, m22, m23, m31, m32, m33};

  matrix_3x3_gen #(
    .IMG_HDISP(HD),
    .IMG_VDISP(VD),
    .DATA_W   (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_vsync       (in_vsync),
    .in_href        (in_href),
    .in_data        (in_data),
    .taps0x         (taps0x),
    .taps1x         (taps1x),
    .line_ce        (line_ce),
    .m11            (m11),
    .m12            (m12),
    .m13            (m13),
    .m21            (m21),
    .m22            (m22),
    .m23            (m23),
    .m31            (m31),
    .m32            (m32),
    .m33            (m33),
    .out_vsync      (out_vsync),
    .out_href       (out_href),
    .out_frame_start(out_frame_start)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [71:0] rec_m    [NREC];
  logic        rec_href [NREC];
  logic        rec_vs   [NREC];
  logic        rec_fs   [NREC];
  int          pix_cyc  [8][8];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c + 1);
  endfunction

  // One clock; outputs are recorded 1 ns after the edge under the new index.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < NREC) begin
      rec_m[cyc]    = w_win;
      rec_href[cyc] = out_href;
      rec_vs[cyc]   = out_vsync;
      rec_fs[cyc]   = out_frame_start;
    end
  endtask

  task automatic drive_pix(input int r, input int c);
    in_href = 1'b1;
    in_data = pix(r, c);
    taps0x  = (r >= 1) ? pix(r - 1, c) : 8'h00;
    taps1x  = (r >= 2) ? pix(r - 2, c) : 8'h00;
    pix_cyc[r][c] = cyc;
    tick();
  endtask

  task automatic blank(input int n);
    in_href = 1'b0;
    in_data = '0;
    taps0x  = '0;
    taps1x  = '0;
    repeat (n) tick();
  endtask

  task automatic drive_line(input int r, input int n);
    for (int c = 0; c < n; c++) drive_pix(r, c);
    blank(3);
  endtask

  task automatic frame_sync(output int vs_at);
    in_vsync = 1'b1;
    vs_at    = cyc;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
    tick();
  endtask

  function automatic int count_fs(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (rec_fs[k] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vs_at;
    int fs0;
    int t;
    int rc;

    // Reset held 3 cycles with in_href toggling.
    rst_n   = 1'b0;
    in_href = 1'b1;
    #1;
    chk("line_ce_rst_a", 72'(line_ce), 72'(1));
    tick();
    in_href = 1'b0;
    #1;
    chk("line_ce_rst_b", 72'(line_ce), 72'(0));
    tick();
    in_href = 1'b1;
    #1;
    chk("line_ce_rst_c", 72'(line_ce), 72'(1));
    tick();
    chk("rst_window", w_win, 72'(0));
    chk("rst_href", 72'(out_href), 72'(0));
    chk("rst_vsync", 72'(out_vsync), 72'(0));
    chk("rst_fstart", 72'(out_frame_start), 72'(0));
    in_href = 1'b0;
    rst_n   = 1'b1;
    blank(2);

    // Frame 1: nominal 4x3 frame.
    fs0 = cyc;
    frame_sync(vs_at);
    chk("vsync_t1", 72'(rec_vs[vs_at + 1]), 72'(0));
    chk("vsync_t2", 72'(rec_vs[vs_at + 2]), 72'(1));
    for (int r = 0; r < 3; r++) drive_line(r, 4);
    t = pix_cyc[0][0];
    chk("href_t1", 72'(rec_href[t + 1]), 72'(0));
    chk("href_t2", 72'(rec_href[t + 2]), 72'(1));
    chk("fstart_t2", 72'(rec_fs[t + 2]), 72'(1));
    chk("fstart_count", 72'(count_fs(fs0, cyc)), 72'(1));
    chk("win_r0c0", rec_m[pix_cyc[0][0] + 2], E00);
    chk("win_r1c0", rec_m[pix_cyc[1][0] + 2], E10);
    chk("win_r1c1", rec_m[pix_cyc[1][1] + 2], E11);
    chk("win_r2c3", rec_m[pix_cyc[2][3] + 2], E23);
    chk("win_r0c3", rec_m[pix_cyc[0][3] + 2], E03);
    chk("hold_href", 72'(rec_href[pix_cyc[0][3] + 3]), 72'(0));
    chk("hold_win", rec_m[pix_cyc[0][3] + 3], E03);

    // Frame 2: one line too many; row counter must park at VD-1.
    frame_sync(vs_at);
    for (int r = 0; r < 4; r++) drive_line(r, 4);
    chk("row_sat", 72'(dut.r_row_cnt), 72'(VD - 1));
    chk("win_r3c2", rec_m[pix_cyc[3][2] + 2], E32);

    // Frame 3: 6-pixel line, then a frame start on the same cycle as the line end.
    frame_sync(vs_at);
    for (int c = 0; c < 6; c++) drive_pix(0, c);
    chk("col_sat", 72'(dut.r_col_cnt), 72'(HD - 1));
    in_href  = 1'b0;
    in_data  = '0;
    in_vsync = 1'b1;
    tick();
    chk("row_clear_wins", 72'(dut.r_row_cnt), 72'(0));
    tick();
    in_vsync = 1'b0;
    blank(3);
    chk("win_r0c5", rec_m[pix_cyc[0][5] + 2], E05);

    // Frame 4: reset pulse at row 1, col 2, then restart.
    frame_sync(vs_at);
    drive_line(0, 4);
    drive_pix(1, 0);
    drive_pix(1, 1);
    in_href = 1'b1;
    in_data = pix(1, 2);
    taps0x  = pix(0, 2);
    taps1x  = 8'h00;
    rst_n   = 1'b0;
    rc      = cyc;
    tick();
    rst_n = 1'b1;
    blank(4);
    chk("midrst_win", rec_m[rc + 1], 72'(0));
    chk("midrst_href", 72'(rec_href[rc + 1]), 72'(0));
    chk("midrst_href2", 72'(rec_href[rc + 2]), 72'(0));
    chk("midrst_row", 72'(dut.r_row_cnt), 72'(0));
    fs0 = cyc;
    frame_sync(vs_at);
    drive_line(0, 4);
    chk("restart_fstart", 72'(rec_fs[pix_cyc[0][0] + 2]), 72'(1));
    chk("restart_count", 72'(count_fs(fs0, cyc)), 72'(1));
    chk("restart_r0c0", rec_m[pix_cyc[0][0] + 2], E00);
    chk("restart_r0c3", rec_m[pix_cyc[0][3] + 2], E03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
